// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchronizer, 16x oversampling frame FSM with
// parity/stop checking, and a small receive FIFO with overflow detection.
module uart_rx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 12
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic                          cfg_rx_en,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_stop_bits,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_even,
  input  logic [DIV_W-1:0]              cfg_divisor,
  input  logic                          rxd,
  input  logic                          rx_rd,
  output logic [7:0]                    rx_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_busy,
  output logic                          par_err,
  output logic                          frm_err,
  output logic                          ovf_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  // Data bits above the character length are zero, so the full byte can be reduced.
  function automatic logic par_fail(input logic [7:0] data, input logic par_bit,
                                    input logic even);
    par_fail = (^data) ^ par_bit ^ ~even;
  endfunction

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               rxd_s_q, rxd_s_d;
  logic               prev_q, prev_d;
  logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]         tcnt_q, tcnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         data_q, data_d;
  logic               par_bit_q, par_bit_d;
  logic               frm_q, frm_d;
  logic               busy_q, busy_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               ovf_err_q, ovf_err_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               tick_s, mid_s, end_s, fall_s, finish_s, frm_sample_s;
  logic [2:0]         last_idx_s;
  logic               rd_s, full_s, wr_ok_s;

  // Receive FSM, oversample timing and error pulse generation.
  always_comb begin
    sync1_d      = rxd;
    rxd_s_d      = sync1_q;
    prev_d       = rxd_s_q;
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    data_d       = data_q;
    par_bit_d    = par_bit_q;
    frm_d        = frm_q;
    finish_s     = 1'b0;
    fall_s       = prev_q & ~rxd_s_q;
    last_idx_s   = {1'b0, cfg_data_bits} + 3'd4;
    tick_s       = (state_q != IDLE) && (tick_cnt_q == '0);
    mid_s        = tick_s && (tcnt_q == 4'd7);
    end_s        = tick_s && (tcnt_q == 4'd15);
    frm_sample_s = frm_q | ~rxd_s_q;

    // IDLE keeps the divider preloaded so the first tick lands divisor+1 cycles in.
    if (state_q == IDLE) begin
      tick_cnt_d = cfg_divisor;
      tcnt_d     = 4'd0;
    end else if (tick_s) begin
      tick_cnt_d = cfg_divisor;
      tcnt_d     = tcnt_q + 4'd1;
    end else begin
      tick_cnt_d = tick_cnt_q - DIV_W'(1);
      tcnt_d     = tcnt_q;
    end

    if (!cfg_rx_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall_s) begin
            state_d   = START;
            data_d    = 8'd0;
            bit_idx_d = 3'd0;
            par_bit_d = 1'b0;
            frm_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (mid_s && rxd_s_q) begin
            state_d = IDLE;
          end else if (end_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (mid_s) begin
            data_d[bit_idx_q] = rxd_s_q;
          end else if (end_s) begin
            if (bit_idx_q == last_idx_s) begin
              state_d = cfg_par_en ? PARITY : STOP1;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          if (mid_s) begin
            par_bit_d = rxd_s_q;
          end else if (end_s) begin
            state_d = STOP1;
          end else begin
            state_d = PARITY;
          end
        end
        STOP1: begin
          if (mid_s && !cfg_stop_bits) begin
            finish_s = 1'b1;
            state_d  = IDLE;
          end else if (mid_s) begin
            frm_d = frm_sample_s;
          end else if (end_s) begin
            state_d = STOP2;
          end else begin
            state_d = STOP1;
          end
        end
        STOP2: begin
          if (mid_s) begin
            finish_s = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = STOP2;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d    = (state_d != IDLE);
    par_err_d = finish_s && cfg_par_en && par_fail(data_q, par_bit_q, cfg_par_even);
    frm_err_d = finish_s && frm_sample_s;
  end

  // FIFO bookkeeping; a full FIFO accepts a write only when the same cycle pops.
  always_comb begin
    rd_s      = rx_rd && (count_q != '0);
    full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    wr_ok_s   = finish_s && (!full_s || rd_s);
    ovf_err_d = finish_s && full_s && !rd_s;
    mem_d     = mem_q;
    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = data_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; the synchronizer and edge history reset to the idle level.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      prev_q     <= 1'b1;
      tick_cnt_q <= '0;
      tcnt_q     <= 4'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'd0;
      par_bit_q  <= 1'b0;
      frm_q      <= 1'b0;
      busy_q     <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rxd_s_q    <= rxd_s_d;
      prev_q     <= prev_d;
      tick_cnt_q <= tick_cnt_d;
      tcnt_q     <= tcnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      frm_q      <= frm_d;
      busy_q     <= busy_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovf_err_q  <= ovf_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_empty = (count_q == '0);
  assign rx_count = count_q;
  assign rx_busy  = busy_q;
  assign par_err  = par_err_q;
  assign frm_err  = frm_err_q;
  assign ovf_err  = ovf_err_q;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter FIFO_DEPTH SHALL default to 4 and set the receive FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter DIV_W SHALL default to 12 and set the divisor width.
REQ-003 mclk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 cfg_rx_en  in  1  SHALL enable reception; 0 forces the receiver to idle.
REQ-006 cfg_data_bits  in  2  SHALL select the character length, equal to the field value + 5 (5..8 bits).
REQ-007 cfg_stop_bits  in  1  SHALL select the stop bits checked: 0 = one, 1 = two.
REQ-008 cfg_par_en  in  1  SHALL enable the parity bit after the data bits.
REQ-009 cfg_par_even  in  1  SHALL select the parity sense: 1 = even, 0 = odd.
REQ-010 cfg_divisor  in  DIV_W  SHALL set the oversample tick period to cfg_divisor+1 mclk cycles; one bit = 16 ticks.
REQ-011 rxd  in  1  SHALL be the asynchronous serial input; idle level is 1; LSB is received first.
REQ-012 rx_rd  in  1  SHALL pop the FIFO head when rx_empty=0.
REQ-013 rx_data  out  8  SHALL present the FIFO head, zero-extended above the character length.
REQ-014 rx_empty  out  1  SHALL be high when the FIFO holds 0 entries.
REQ-015 rx_count  out  log2(FIFO_DEPTH)+1  SHALL report the FIFO occupancy.
REQ-016 rx_busy  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-017 par_err, frm_err, ovf_err  out  1 each  SHALL be single-cycle error pulses.

Function
REQ-018 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxd_s.
REQ-019 The tick counter SHALL free-run from cfg_divisor down to 0, assert tick on 0, and reload; it is reset to cfg_divisor on leaving IDLE.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-021 IDLE->START SHALL occur only on a 1->0 transition of rxd_s while cfg_rx_en=1; a constant-low line never starts a frame.
REQ-022 In START, rxd_s SHALL be sampled at tick 8 (mid-bit): 1 -> return to IDLE with no error (false start); 0 -> DATA after tick 16.
REQ-023 DATA SHALL sample one bit per 16 ticks at mid-bit into bit index 0..N-1, then go to PARITY if cfg_par_en=1, else to STOP1.
REQ-024 PARITY error condition: even mode errs when XOR(data, parity bit) is 1; odd mode errs when it is 0.
REQ-025 STOP1 SHALL sample at mid-bit; a 0 flags a frame error; then go to STOP2 if cfg_stop_bits=1, else to IDLE.
REQ-026 STOP2 SHALL sample at mid-bit; a 0 flags a frame error; then go to IDLE.
REQ-027 The FIFO write, par_err and frm_err SHALL all occur on the mclk cycle after the final stop-bit mid-sample; the FSM then returns to IDLE without waiting out the remaining half bit.
REQ-028 Characters with parity or frame errors SHALL still be written to the FIFO.
REQ-029 A write with the FIFO full and rx_rd=0 SHALL drop the new character and pulse ovf_err; existing contents are unchanged.
REQ-030 A simultaneous write and rx_rd with the FIFO full SHALL accept both with no overflow; with the FIFO empty and a write, rx_rd is ignored that cycle.
REQ-031 rx_rd with rx_empty=1 SHALL be ignored; rx_data holds its value.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be tracked separately to distinguish full from empty.
REQ-033 cfg_rx_en deasserting mid-frame SHALL return the FSM to IDLE within 1 cycle, discard the partial character, and raise no error pulse.
REQ-034 Config inputs SHALL be quasi-static; changing them mid-frame gives undefined content for that frame only.

Reset
REQ-035 On reset: FSM=IDLE, both synchronizer flops=1, FIFO storage and pointers=0, rx_data=0, rx_empty=1, rx_count=0, rx_busy=0, all error pulses=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame; after release, reception restarts only on a new falling edge.

Verification
REQ-037 8N1, divisor=0 (16 mclk/bit), send 0xA5 -> rx_empty falls; rx_data=0xA5, rx_count=1, no error pulses; rx_rd -> rx_empty=1.
REQ-038 7E2, send 0x35 with the parity bit inverted -> par_err pulses once; rx_data=0x35; frm_err=0.
REQ-039 Pull rxd low for 3 mclk with divisor=0 -> no write; rx_busy returns to 0 by tick 8; no errors.
REQ-040 8N1, send 0x3C with stop=0, then hold rxd low for 40 bits -> one frm_err and one write (0x3C); no second frame until rxd rises and falls again.
REQ-041 FIFO_DEPTH=4: send 0x11..0x15 with no reads -> ovf_err pulses on the 5th; reads return 0x11..0x14; then full-plus-read at a write cycle -> no ovf_err.
REQ-042 Assert reset in the middle of DATA bit 3 -> all outputs at reset values; the next full frame 0x5A is received correctly.
